// File: rtl/mult4u_residue_checker_pkg.sv
// Shared types and helpers for the residue-checked 4-bit multiplier stage.
// Holds the FSM state encoding and a mod-3 helper for values up to 8 bits.
package mult4u_chk_pkg;

  localparam int RES_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    OUT
  } state_e;

  // Sum 2-bit digits, then fold twice: the digit sum of an 8-bit value is at most 12.
  function automatic logic [RES_W-1:0] mod3(input logic [7:0] v);
    logic [4:0] s;
    s = 5'(v[1:0]) + 5'(v[3:2]) + 5'(v[5:4]) + 5'(v[7:6]);
    s = 5'(s[4:2]) + 5'(s[1:0]);
    s = 5'(s[4:2]) + 5'(s[1:0]);
    return (s[1:0] == 2'd3) ? 2'd0 : s[1:0];
  endfunction

endpackage

// File: rtl/mult4u_residue_checker_if.sv
// Operand, multiplier and result signals of the residue checker stage.
// The slave modport is the checker itself; master is whoever surrounds it.
interface mult4u_residue_checker_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_a;
  logic [3:0]           in_b;
  logic [3:0]           mul_a;
  logic [3:0]           mul_b;
  logic [7:0]           mul_p;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_p;
  logic                 out_err;
  logic [1:0]           out_retries;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_p, out_err, out_retries, err_count
  );

  modport master (
    output in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_p, out_err, out_retries, err_count
  );
endinterface

// File: rtl/mult4u_residue_checker_mod3.sv
// Combinational W-bit to 2-bit mod-3 residue.
// Adds the 2-bit digits, then folds the sum until it drops below 4.
module mod3_residue
  import mult4u_chk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]     value_i,
  output logic [RES_W-1:0] res_o
);

  localparam int ND = (W + 1) / 2;
  localparam int PW = 2 * ND;
  localparam int SW = W + 2;

  logic [PW-1:0] padded;
  logic [SW-1:0] acc;

  assign padded = PW'(value_i);

  // Each fold maps x to (x>>2)+(x&3), which keeps x mod 3 and shrinks any x >= 4.
  always_comb begin
    acc = '0;
    for (int i = 0; i < ND; i++) begin
      acc = acc + SW'(padded[2*i +: 2]);
    end
    for (int k = 0; k < SW; k++) begin
      acc = (acc >> 2) + SW'(acc[1:0]);
    end
    res_o = (acc[1:0] == 2'd3) ? '0 : acc[1:0];
  end

endmodule

// File: rtl/mult4u_residue_checker.sv
// Drives the combinational 4x4 multiplier, samples its product after a settle time,
// verifies it with a mod-3 residue test and retries a bounded number of times on mismatch.
module mult4u_residue_checker
  import mult4u_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mult4u_residue_checker_if.slave bus
);

  localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRY < 3) ? 2 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [3:0]           opA_q, opA_d;
  logic [3:0]           opB_q, opB_d;
  logic [7:0]           prod_q, prod_d;
  logic [CNT_W-1:0]     settleCnt_q, settleCnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] errCount_q, errCount_d;

  logic [RES_W-1:0] resA, resB, resP;
  logic [3:0]       resProd;
  logic             residueOk;

  mod3_residue #(.W(4)) uResA (.value_i(opA_q),  .res_o(resA));
  mod3_residue #(.W(4)) uResB (.value_i(opB_q),  .res_o(resB));
  mod3_residue #(.W(8)) uResP (.value_i(prod_q), .res_o(resP));

  assign resProd   = 4'(resA) * 4'(resB);
  assign residueOk = (mod3({4'b0, resProd}) == resP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      prod_q      <= '0;
      settleCnt_q <= '0;
      retry_q     <= '0;
      err_q       <= 1'b0;
      errCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      prod_q      <= prod_d;
      settleCnt_q <= settleCnt_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      errCount_q  <= errCount_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    prod_d      = prod_q;
    settleCnt_d = settleCnt_q;
    retry_d     = retry_q;
    err_d       = err_q;
    errCount_d  = errCount_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opA_d       = bus.in_a;
          opB_d       = bus.in_b;
          retry_d     = '0;
          err_d       = 1'b0;
          settleCnt_d = SETTLE_LOAD;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (settleCnt_q == '0) begin
          prod_d  = bus.mul_p;
          state_d = CHECK;
        end else begin
          settleCnt_d = settleCnt_q - 1'b1;
        end
      end
      CHECK: begin
        if (residueOk) begin
          err_d   = 1'b0;
          state_d = OUT;
        end else if (retry_q != RETRY_MAX) begin
          retry_d     = retry_q + 1'b1;
          settleCnt_d = SETTLE_LOAD;
          state_d     = SETTLE;
        end else begin
          err_d   = 1'b1;
          state_d = OUT;
          if (errCount_q != '1) begin
            errCount_d = errCount_q + 1'b1;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked by reset so nothing upstream sees a ready stage while held in reset.
  assign bus.in_ready    = rst_n && (state_q == IDLE);
  assign bus.mul_a       = opA_q;
  assign bus.mul_b       = opB_q;
  assign bus.out_valid   = (state_q == OUT);
  assign bus.out_p       = prod_q;
  assign bus.out_err     = err_q;
  assign bus.out_retries = (retry_q >= RETRY_W'(3)) ? 2'd3 : retry_q[1:0];
  assign bus.err_count   = errCount_q;

endmodule

// File: tb/tb_mult4u_residue_checker.sv
// Self-checking bench: a fault-injecting multiplier model, a transaction-level expectation
// model and a per-cycle compare process, plus directed cases pinned to literal values.
module tb_mult4u_residue_checker;

  localparam int S     = 2;
  localparam int MR    = 3;
  localparam int ERR_W = 2;

  logic clock = 1'b0;
  logic rst_n;

  always #5 clock = ~clock;

  mult4u_residue_checker_if #(.ERR_CNT_W(ERR_W)) bus ();

  mult4u_residue_checker #(
    .SETTLE_CYCLES(S),
    .MAX_RETRY    (MR),
    .ERR_CNT_W    (ERR_W)
  ) dut (
    .clk  (clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  int wrongLeft;
  int wrongCycles;
  logic [7:0] trueP;

  logic [3:0] expA, expB;
  logic [7:0] expP;
  logic       expErr;
  int         expRetries;
  int         expErrCount;
  int         expLatency;
  bit         busy;

  int seenP, seenErr, seenRetries, seenErrCount, seenLatency;

  // The multiplier returns a product off by one in its LSB while a fault window is open,
  // which always disturbs the mod-3 residue.
  assign trueP     = {4'b0, bus.mul_a} * {4'b0, bus.mul_b};
  assign bus.mul_p = (wrongLeft > 0) ? (trueP ^ 8'h01) : trueP;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n)                          wrongLeft <= 0;
    else if (bus.in_valid && bus.in_ready) wrongLeft <= wrongCycles;
    else if (wrongLeft > 0)              wrongLeft <= wrongLeft - 1;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // k = number of consecutive corrupted product samples for this transaction.
  task automatic computeModel(input logic [3:0] a, input logic [3:0] b, input int k);
    int prod;
    int used;
    prod = int'(a) * int'(b);
    expA = a;
    expB = b;
    if (k <= MR) begin
      expP   = 8'(prod);
      expErr = 1'b0;
      used   = k;
    end else begin
      expP   = 8'(prod ^ 1);
      expErr = 1'b1;
      used   = MR;
      if (expErrCount < (1 << ERR_W) - 1) expErrCount++;
    end
    expRetries  = (used > 3) ? 3 : used;
    expLatency  = S + 2 + used * (S + 1);
    wrongCycles = (k == 0) ? 0 : k * (S + 1) - 1;
  endtask

  always @(posedge clock) begin
    #1;
    if (rst_n === 1'b1) begin
      if (busy) begin
        if (bus.out_valid) begin
          checkOutput("outP",       int'(bus.out_p),       int'(expP));
          checkOutput("outErr",     int'(bus.out_err),     int'(expErr));
          checkOutput("outRetries", int'(bus.out_retries), expRetries);
          checkOutput("errCount",   int'(bus.err_count),   expErrCount);
          checkOutput("busyReady",  int'(bus.in_ready),    0);
          checkOutput("mulA",       int'(bus.mul_a),       int'(expA));
          checkOutput("mulB",       int'(bus.mul_b),       int'(expB));
        end
      end else begin
        checkOutput("idleValid",    int'(bus.out_valid),   0);
        checkOutput("idleReady",    int'(bus.in_ready),    1);
        checkOutput("idleErrCount", int'(bus.err_count),   expErrCount);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input int k,
                               input int hold);
    int n;
    int lat;
    busy = 1'b1;
    computeModel(a, b, k);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput("acceptTimeout", 0, 1);
      bus.in_valid = 1'b0;
      busy = 1'b0;
      return;
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("latency", lat, expLatency);
    seenLatency  = lat;
    seenP        = int'(bus.out_p);
    seenErr      = int'(bus.out_err);
    seenRetries  = int'(bus.out_retries);
    seenErrCount = int'(bus.err_count);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 4'($urandom);
      bus.in_b     = 4'($urandom);
      @(negedge clock);
      checkOutput("heldValid", int'(bus.out_valid), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    checkOutput("releasedValid", int'(bus.out_valid), 0);
    busy = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int satExp[5];
    satExp = '{1, 2, 3, 3, 3};
    busy          = 1'b1;
    wrongCycles   = 0;
    expErrCount   = 0;
    expA          = '0;
    expB          = '0;
    expP          = '0;
    expErr        = 1'b0;
    expRetries    = 0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #1;
    checkOutput("rstReady",    int'(bus.in_ready),  0);
    checkOutput("rstValid",    int'(bus.out_valid), 0);
    checkOutput("rstMulA",     int'(bus.mul_a),     0);
    checkOutput("rstOutP",     int'(bus.out_p),     0);
    checkOutput("rstErrCount", int'(bus.err_count), 0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    busy  = 1'b0;
    @(negedge clock);

    applyStimulus(4'd13, 4'd11, 0, 0);
    checkOutput("cleanP",       seenP,        143);
    checkOutput("cleanErr",     seenErr,      0);
    checkOutput("cleanRetries", seenRetries,  0);
    checkOutput("cleanLatency", seenLatency,  4);

    applyStimulus(4'd13, 4'd11, 1, 0);
    checkOutput("transP",       seenP,        143);
    checkOutput("transErr",     seenErr,      0);
    checkOutput("transRetries", seenRetries,  1);
    checkOutput("transLatency", seenLatency,  7);

    applyStimulus(4'd13, 4'd11, 4, 0);
    checkOutput("stuckP",        seenP,        8'h8E);
    checkOutput("stuckErr",      seenErr,      1);
    checkOutput("stuckRetries",  seenRetries,  3);
    checkOutput("stuckErrCount", seenErrCount, 1);

    applyStimulus(4'd6, 4'd7, 0, 10);
    checkOutput("bpP", seenP, 42);

    // Reset while the stage is settling: nothing may come out afterwards.
    busy = 1'b1;
    computeModel(4'd9, 4'd5, 0);
    bus.in_a     = 4'd9;
    bus.in_b     = 4'd5;
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid",   int'(bus.out_valid),   0);
    checkOutput("midRstReady",   int'(bus.in_ready),    0);
    checkOutput("midRstMulA",    int'(bus.mul_a),       0);
    checkOutput("midRstMulB",    int'(bus.mul_b),       0);
    checkOutput("midRstRetries", int'(bus.out_retries), 0);
    checkOutput("midRstErr",     int'(bus.out_err),     0);
    expErrCount = 0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    busy  = 1'b0;
    #1;
    checkOutput("postRstReady", int'(bus.in_ready), 1);
    for (int i = 0; i < S + 5; i++) begin
      @(negedge clock);
      checkOutput("noResultAfterReset", int'(bus.out_valid), 0);
    end

    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), 4, 0);
      checkOutput("satErrCount", seenErrCount, satExp[i]);
    end

    applyStimulus(4'd0, 4'd15, 0, 0);
    checkOutput("zeroP",   seenP,   0);
    checkOutput("zeroErr", seenErr, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
